// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the shared external memory port. One match core holds
// the port for its whole burst; read data is routed back by an ID pipeline
// that tracks the fixed memory read latency.
module mem_port_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MEM_LAT   = 2,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ-1:0]      rd_wr_i,
    input  logic [NUM_REQ-1:0]      tem_win_i,
    input  logic [NUM_REQ*7-1:0]    row_i,
    input  logic [NUM_REQ*7-1:0]    col_i,
    input  logic [NUM_REQ*8-1:0]    set_i,
    input  logic [NUM_REQ*2-1:0]    wr_index_i,
    input  logic [NUM_REQ*32-1:0]   write_data_i,
    output logic [NUM_REQ-1:0]      gnt_o,
    output logic [NUM_REQ-1:0]      rvalid_o,
    output logic [31:0]             rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_rd_wr_o,
    output logic                    mem_tem_win_o,
    output logic [6:0]              mem_row_o,
    output logic [6:0]              mem_col_o,
    output logic [7:0]              mem_set_o,
    output logic [1:0]              mem_wr_index_o,
    output logic [31:0]             mem_write_data_o,
    input  logic [31:0]             mem_read_data_i,
    output logic                    busy_o
);

    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [ID_W-1:0]     owner_q, owner_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [MEM_LAT-1:0]  pipe_vld_q, pipe_vld_d;
    logic [ID_W-1:0]     pipe_id_q [MEM_LAT];
    logic [ID_W-1:0]     pipe_id_d [MEM_LAT];

    logic [NUM_REQ-1:0]  owner_oh;
    logic                sel_req;
    logic                sel_rd_wr;
    logic                sel_tem_win;
    logic [6:0]          sel_row;
    logic [6:0]          sel_col;
    logic [7:0]          sel_set;
    logic [1:0]          sel_wr_index;
    logic [31:0]         sel_write_data;
    logic                beat;
    logic                others_wait;
    logic                pick_found;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W-1:0]     owner_inc;
    logic                burst_last;

    // Select the current owner's request and command fields.
    always_comb begin
        owner_oh       = '0;
        sel_req        = 1'b0;
        sel_rd_wr      = 1'b0;
        sel_tem_win    = 1'b0;
        sel_row        = '0;
        sel_col        = '0;
        sel_set        = '0;
        sel_wr_index   = '0;
        sel_write_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (owner_q == ID_W'(k)) begin
                owner_oh[k]    = 1'b1;
                sel_req        = req_i[k];
                sel_rd_wr      = rd_wr_i[k];
                sel_tem_win    = tem_win_i[k];
                sel_row        = row_i[k*7 +: 7];
                sel_col        = col_i[k*7 +: 7];
                sel_set        = set_i[k*8 +: 8];
                sel_wr_index   = wr_index_i[k*2 +: 2];
                sel_write_data = write_data_i[k*32 +: 32];
            end
        end
        beat        = (state_q == OWN) && sel_req;
        others_wait = |(req_i & ~owner_oh);
        burst_last  = (beat_cnt_q == BEAT_W'(MAX_BURST - 1));
        owner_inc   = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + ID_W'(1);
    end

    // Round-robin pick: first requester at or above rr_ptr, else lowest index.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_i[k] && (k >= 32'(rr_ptr_q))) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(k);
            end
        end
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_i[k]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(k);
            end
        end
    end

    // Next-state logic for the ownership FSM and burst counter.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = OWN;
                    owner_d    = pick_id;
                    beat_cnt_d = '0;
                end
            end
            OWN: begin
                if (!sel_req) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_inc;
                end else begin
                    beat_cnt_d = burst_last ? '0 : beat_cnt_q + BEAT_W'(1);
                    if (burst_last && others_wait) begin
                        state_d  = IDLE;
                        rr_ptr_d = owner_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read-return pipeline: one {valid, id} stage per cycle of memory latency.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_vld_d[0] = beat && !sel_rd_wr;
        pipe_id_d[0]  = owner_q;
        for (int unsigned s = 1; s < MEM_LAT; s++) begin
            pipe_vld_d[s] = pipe_vld_q[s-1];
            pipe_id_d[s]  = pipe_id_q[s-1];
        end
    end

    // State, arbitration and pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            pipe_vld_q <= '0;
            for (int unsigned s = 0; s < MEM_LAT; s++) begin
                pipe_id_q[s] <= '0;
            end
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            pipe_vld_q <= pipe_vld_d;
            for (int unsigned s = 0; s < MEM_LAT; s++) begin
                pipe_id_q[s] <= pipe_id_d[s];
            end
        end
    end

    // Grant decode, read-valid routing and memory command forwarding.
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            gnt_o[k]    = (state_q == OWN) && (owner_q == ID_W'(k));
            rvalid_o[k] = pipe_vld_q[MEM_LAT-1] && (pipe_id_q[MEM_LAT-1] == ID_W'(k));
        end
        rdata_o          = mem_read_data_i;
        mem_req_o        = beat;
        mem_rd_wr_o      = beat ? sel_rd_wr      : 1'b0;
        mem_tem_win_o    = beat ? sel_tem_win    : 1'b0;
        mem_row_o        = beat ? sel_row        : '0;
        mem_col_o        = beat ? sel_col        : '0;
        mem_set_o        = beat ? sel_set        : '0;
        mem_wr_index_o   = beat ? sel_wr_index   : '0;
        mem_write_data_o = beat ? sel_write_data : '0;
        busy_o           = (state_q == OWN) || (|pipe_vld_q);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that shares the single external memory port between `NUM_REQ` independent match cores. Each core issues template/window reads and result writes. The arbiter grants the port to one core at a time and holds the grant for the core's whole burst. It forwards the owner's command fields to memory and routes returned read data back to the requester that issued each read, using an ID-tracking latency pipeline. It sits between the per-core frame sequencers and the memory controller.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesting cores (2..8).
- `MEM_LAT`, default 2: fixed cycles from a read beat to valid `mem_read_data_i` (1..4).
- `MAX_BURST`, default 64: beats after which the grant is forcibly released if another core is waiting.

Ports (packed per-requester vectors, requester k at slice k):
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_i`  in  NUM_REQ  requester wants the port; held high for the whole burst.
- `rd_wr_i`  in  NUM_REQ  0 = read, 1 = write.
- `tem_win_i`  in  NUM_REQ  0 = template, 1 = window.
- `row_i`, `col_i`  in  NUM_REQ*7 each  patch row/col.
- `set_i`  in  NUM_REQ*8  set number (write addressing).
- `wr_index_i`  in  NUM_REQ*2  result word index 0..2.
- `write_data_i`  in  NUM_REQ*32  write word.
- `gnt_o`  out  NUM_REQ  one-hot grant; a beat occurs when `req_i[k] & gnt_o[k]`.
- `rvalid_o`  out  NUM_REQ  one-hot read-data-valid pulse.
- `rdata_o`  out  32  read data, shared by all requesters; qualified by `rvalid_o`.
- `mem_req_o`, `mem_rd_wr_o`, `mem_tem_win_o`  out  1 each  memory command.
- `mem_row_o`, `mem_col_o`  out  7 each; `mem_set_o`  out  8; `mem_wr_index_o`  out  2; `mem_write_data_o`  out  32.
- `mem_read_data_i`  in  32  memory read data.
- `busy_o`  out  1  high while in OWN or any read is outstanding.

## Operation
- State machine with two states, IDLE and OWN. Registers: `owner` (log2 NUM_REQ bits), `rr_ptr`, `beat_cnt` (log2 MAX_BURST bits).
- IDLE: if `req_i` != 0, pick the first asserted requester scanning `rr_ptr`, `rr_ptr`+1, … mod NUM_REQ. Load `owner`, clear `beat_cnt`, and go to OWN. Otherwise stay in IDLE.
- OWN:
  - `gnt_o` = onehot(`owner`), decoded from state/owner registers, not from `req_i`.
  - Beat, defined as `req_i[owner]` = 1:
    - `mem_req_o` = 1.
    - All `mem_*` command fields equal the owner's slices, combinationally.
    - `beat_cnt` increments, wrapping to 0.
  - No beat: `mem_req_o` = 0 and all `mem_*` command outputs are driven 0.
  - Normal release: `req_i[owner]` = 0 → next state IDLE, `rr_ptr` = `owner`+1 mod NUM_REQ.
  - Forced release: a beat with `beat_cnt` = MAX_BURST-1 while `req_i & ~onehot(owner)` != 0 → the beat completes, next state IDLE, `rr_ptr` = `owner`+1. The preempted core keeps `req_i` high and waits for a new grant.
  - If no other core is waiting at MAX_BURST-1, `beat_cnt` wraps and the grant is kept.
- Read return:
  - Shift pipeline of depth MEM_LAT; each stage holds {valid, id}.
  - Stage 0 loads {beat & ~`rd_wr`, `owner`}.
  - At the last stage, `rvalid_o[id]` = valid and `rdata_o` = `mem_read_data_i` (combinational).
  - The pipeline runs independently of the FSM, so reads stay correctly routed across owner changes.
- Writes produce no response.

## Timing
- Reset values:
  - state IDLE; `owner`, `rr_ptr`, `beat_cnt` = 0; pipeline valid bits = 0.
  - Outputs: `gnt_o` = 0, `rvalid_o` = 0, `mem_req_o` = 0, all `mem_*` = 0, `rdata_o` = `mem_read_data_i` passthrough, `busy_o` = 0.
- Grant latency: `req_i[k]` rises in cycle t while in IDLE → `gnt_o[k]` high and first beat possible at t+1.
- Handover gap:
  - Owner drops `req_i` in cycle t → `gnt_o` low at t+1 (IDLE, arbitration) → next owner granted at t+2.
  - There is exactly one idle memory cycle between owners.
- Read latency: beat in cycle t → `rvalid_o[id]` in cycle t+MEM_LAT.
- Simultaneous requests: resolved only by `rr_ptr`; a requester asserting `req_i` in the IDLE cycle is eligible that cycle.
- A requester that drops `req_i` while not granted is ignored, with no side effects.
- Reset mid-operation: asynchronous clear of the FSM and the pipeline. In-flight reads are discarded and no `rvalid_o` fires after reset.

## Test plan
- Single core 0 holds `req_i` for 8 read beats, MEM_LAT=2 → `gnt_o`=0001 one cycle after request; 8 `rvalid_o[0]` pulses starting 2 cycles after the first beat; `mem_row_o`/`mem_col_o` track core 0.
- Cores 0 and 2 request in the same cycle with `rr_ptr`=0 → core 0 granted first. After core 0 drops `req_i`: one IDLE cycle, then `gnt_o`=0100, and `rr_ptr` becomes 3 after core 2 releases.
- MAX_BURST=4, core 1 streams continuously, core 3 waiting → core 1 released after its 4th beat, core 3 granted 2 cycles later, core 1 re-granted after core 3 releases.
- Core 0's last read beat is immediately followed by handover to core 1's reads → `rvalid_o[0]` for core 0's tail data, then `rvalid_o[1]`; no misrouted pulse.
- Write burst with `wr_index_i` 0,1,2, `set_i`=5 → three `mem_req_o` beats with `mem_rd_wr_o`=1 and matching index/data; no `rvalid_o`.
- Assert `rst_n`=0 one cycle after a read beat with MEM_LAT=3 → all outputs at reset values immediately; no `rvalid_o` after reset is released.
